// File: rtl/alu_issue_if.sv
// ALU issue bus: fetch/regfile side (instruction offer, regfile read) and the
// ALU side (decoded aluop/op1/op2 with valid/ready).
//   master : the issue unit (accepts instructions, drives decoded fields)
//   slave  : the environment (fetch, regfile, ALU)
// Optional macro ALU_ISSUE_WORD_OPS_EN adds word_o (RV64 *W instructions).
interface alu_issue_if #(
   parameter int XLEN = 64,
   parameter int AOPW = 4
);
   logic            inst_valid_i;
   logic            inst_ready_o;
   logic [31:0]     inst_i;
   logic [XLEN-1:0] pc_i;
   logic [4:0]      rs1_addr_o;
   logic [4:0]      rs2_addr_o;
   logic [XLEN-1:0] rs1_data_i;
   logic [XLEN-1:0] rs2_data_i;
   logic            alu_valid_o;
   logic            alu_ready_i;
   logic [AOPW-1:0] aluop_o;
   logic [XLEN-1:0] op1_o;
   logic [XLEN-1:0] op2_o;
   logic [4:0]      rd_o;
   logic            wen_o;
   logic            illegal_o;
`ifdef ALU_ISSUE_WORD_OPS_EN
   logic            word_o;
`endif

   modport master (
      input  inst_valid_i, inst_i, pc_i, rs1_data_i, rs2_data_i, alu_ready_i,
`ifdef ALU_ISSUE_WORD_OPS_EN
      output word_o,
`endif
      output inst_ready_o, rs1_addr_o, rs2_addr_o, alu_valid_o, aluop_o,
             op1_o, op2_o, rd_o, wen_o, illegal_o
   );

   modport slave (
      output inst_valid_i, inst_i, pc_i, rs1_data_i, rs2_data_i, alu_ready_i,
`ifdef ALU_ISSUE_WORD_OPS_EN
      input  word_o,
`endif
      input  inst_ready_o, rs1_addr_o, rs2_addr_o, alu_valid_o, aluop_o,
             op1_o, op2_o, rd_o, wen_o, illegal_o
   );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: decodes RV64I integer ALU instructions (OP, OP-IMM, LUI, AUIPC)
// into aluop/op1/op2 and hands them to the ALU through a registered 2-entry
// skid buffer (main entry drives outputs, skid entry absorbs one stall).
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : alu_issue_if.master (instruction in, regfile read, ALU out)
// Optional macro ALU_ISSUE_WORD_OPS_EN: decode OP-IMM-32 / OP-32 and drive
// bus.word_o; without it those opcodes are reported illegal.
module alu_issue #(
   parameter int XLEN = 64,
   parameter int AOPW = 4
) (
   input logic         clk,
   input logic         rst_n,
   alu_issue_if.master bus
);
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
`ifdef ALU_ISSUE_WORD_OPS_EN
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
`endif

   localparam logic [AOPW-1:0] ALU_ADD  = 4'b0000;
   localparam logic [AOPW-1:0] ALU_SUB  = 4'b0001;
   localparam logic [AOPW-1:0] ALU_SLT  = 4'b0010;
   localparam logic [AOPW-1:0] ALU_SLL  = 4'b0011;
   localparam logic [AOPW-1:0] ALU_SRL  = 4'b0100;
   localparam logic [AOPW-1:0] ALU_SRA  = 4'b0101;
   localparam logic [AOPW-1:0] ALU_AND  = 4'b0110;
   localparam logic [AOPW-1:0] ALU_OR   = 4'b0111;
   localparam logic [AOPW-1:0] ALU_XOR  = 4'b1000;
   localparam logic [AOPW-1:0] ALU_SLTU = 4'b1001;

   typedef struct packed {
      logic [AOPW-1:0] aluop;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [4:0]      rd;
      logic            wen;
      logic            illegal;
      logic            word;
   } entry_t;

   // alt selects sub for funct3=000 and sra for funct3=101
   function automatic logic [AOPW-1:0] alu_fn(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_fn = ALU_SLL;
         3'b010:  alu_fn = ALU_SLT;
         3'b011:  alu_fn = ALU_SLTU;
         3'b100:  alu_fn = ALU_XOR;
         3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_fn = ALU_OR;
         default: alu_fn = ALU_AND;
      endcase
   endfunction

   logic [31:0]     inst;
   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_u, shamt;
   logic            is_shift, f7_ok, legal;
   entry_t          dec;

   assign inst   = bus.inst_i;
   assign opcode = inst[6:0];
   assign f3     = inst[14:12];
   assign f7     = inst[31:25];
   assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
   assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
   assign shamt  = {{(XLEN-6){1'b0}}, inst[25:20]};
   assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
   // register-register forms: funct7 must be 0, or 0100000 only for sub/sra
   assign f7_ok  = (f7 == 7'b0000000) ||
                   ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));

   assign bus.rs1_addr_o = inst[19:15];
   assign bus.rs2_addr_o = inst[24:20];

   always_comb begin
      dec    = '0;
      legal  = 1'b1;
      dec.rd = inst[11:7];
      case (opcode)
         OPC_OP_IMM: begin
            dec.aluop = alu_fn(f3, (f3 == 3'b101) && inst[30]);
            dec.op1   = bus.rs1_data_i;
            dec.op2   = is_shift ? shamt : imm_i;
         end
         OPC_OP: begin
            legal     = f7_ok;
            dec.aluop = alu_fn(f3, inst[30]);
            dec.op1   = bus.rs1_data_i;
            dec.op2   = bus.rs2_data_i;
         end
         OPC_LUI: begin
            dec.aluop = ALU_ADD;
            dec.op2   = imm_u;
         end
         OPC_AUIPC: begin
            dec.aluop = ALU_ADD;
            dec.op1   = bus.pc_i;
            dec.op2   = imm_u;
         end
`ifdef ALU_ISSUE_WORD_OPS_EN
         OPC_OP_IMM32: begin
            // only addiw/slliw/srliw/sraiw; W-shift amounts above 31 are illegal
            legal     = ((f3 == 3'b000) || is_shift) && !(is_shift && inst[25]);
            dec.aluop = alu_fn(f3, (f3 == 3'b101) && inst[30]);
            dec.op1   = bus.rs1_data_i;
            dec.op2   = is_shift ? shamt : imm_i;
            dec.word  = 1'b1;
         end
         OPC_OP32: begin
            legal     = ((f3 == 3'b000) || is_shift) && f7_ok;
            dec.aluop = alu_fn(f3, inst[30]);
            dec.op1   = bus.rs1_data_i;
            dec.op2   = bus.rs2_data_i;
            dec.word  = 1'b1;
         end
`endif
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         // illegal: neutral add 0+0, no writeback, rd kept for the caller
         dec.aluop   = ALU_ADD;
         dec.op1     = '0;
         dec.op2     = '0;
         dec.word    = 1'b0;
         dec.illegal = 1'b1;
      end else begin
         dec.wen     = (dec.rd != 5'd0);
      end
   end

   // ---- skid buffer: occupancy EMPTY / ONE (main) / TWO (main + skid) ----
   entry_t main_q, skid_q;
   logic   main_vld, skid_vld;
   logic   accept, out_xfer;

   assign accept   = bus.inst_valid_i && !skid_vld;
   assign out_xfer = main_vld && bus.alu_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else if (!main_vld) begin
         if (accept) begin
            main_q   <= dec;
            main_vld <= 1'b1;
         end
      end else if (out_xfer) begin
         if (skid_vld) begin
            // TWO -> ONE: skid promotes; no accept possible this cycle
            main_q   <= skid_q;
            skid_vld <= 1'b0;
         end else if (accept) begin
            main_q   <= dec;
         end else begin
            main_vld <= 1'b0;
         end
      end else if (accept) begin
         // stalled with main full: park the new instruction in the skid entry
         skid_q   <= dec;
         skid_vld <= 1'b1;
      end
   end

   assign bus.inst_ready_o = !skid_vld;
   assign bus.alu_valid_o  = main_vld;
   assign bus.aluop_o      = main_q.aluop;
   assign bus.op1_o        = main_q.op1;
   assign bus.op2_o        = main_q.op2;
   assign bus.rd_o         = main_q.rd;
   assign bus.wen_o        = main_q.wen;
   assign bus.illegal_o    = main_q.illegal;
`ifdef ALU_ISSUE_WORD_OPS_EN
   assign bus.word_o       = main_q.word;
`endif
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Producer side of the ALU operand interface: decodes RV64I integer instructions into aluop/op1/op2 and drives them to the ALU.
- Sits between the fetch/regfile and the ALU.
- Registered output with a 2-entry skid buffer and valid/ready handshakes on both sides, so the ALU side can stall without losing instructions.

Parameters:
- XLEN, 64, operand/PC width (RegBus width)
- AOPW, 4, aluop width (aluopLength)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active-low
- inst_valid_i  in  1  fetch offers an instruction
- inst_ready_o  out  1  issue can accept this cycle
- inst_i  in  32  instruction word
- pc_i  in  XLEN  instruction address
- rs1_addr_o  out  5  regfile read address, combinational = inst_i[19:15]
- rs2_addr_o  out  5  regfile read address, combinational = inst_i[24:20]
- rs1_data_i  in  XLEN  regfile read data, same cycle
- rs2_data_i  in  XLEN  regfile read data, same cycle
- alu_valid_o  out  1  output fields valid
- alu_ready_i  in  1  ALU/consumer accepts
- aluop_o  out  AOPW  operation code
- op1_o  out  XLEN  first operand
- op2_o  out  XLEN  second operand
- rd_o  out  5  destination register
- wen_o  out  1  writeback enable
- illegal_o  out  1  instruction not decodable by this unit

Behaviour:
- aluop encoding (fixed):
  - 0000 add, 0001 sub, 0010 slt, 0011 sll, 0100 srl, 0101 sra
  - 0110 and, 0111 or, 1000 xor, 1001 sltu
- Decode by opcode:
  - OP-IMM 0010011: op1=rs1, op2=sign-extended I-imm
  - OP 0110011: op1=rs1, op2=rs2
  - LUI 0110111: aluop add, op1=0, op2=sign-extended U-imm
  - AUIPC 0010111: aluop add, op1=pc_i, op2=sign-extended U-imm
- funct3 mapping:
  - 000 add; sub only for OP with funct7=0100000
  - 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and
  - 101: srl if inst[30]=0, sra if inst[30]=1
  - OP-IMM shifts: shamt = inst[25:20], op2 zero-extended
- Illegal cases:
  - Condition: any other opcode, or OP with funct7 not in {0000000, 0100000}, or funct7=0100000 with funct3 not in {000, 101}.
  - Response: illegal_o=1, wen_o=0, aluop add, op1=op2=0; rd_o still carried.
- wen_o = legal and rd != 0.
- Handshake:
  - Input transfer when inst_valid_i & inst_ready_o.
  - Output transfer when alu_valid_o & alu_ready_i.
  - Outputs hold stable while alu_valid_o=1 and alu_ready_i=0.
- Skid buffer:
  - Entries: main (drives outputs) and skid.
  - inst_ready_o = skid empty (registered, no combinational path from alu_ready_i).
- States (by occupancy):
  - EMPTY to ONE on accept.
  - ONE to ONE on accept plus output transfer in the same cycle.
  - ONE to TWO on accept while stalled.
  - ONE to EMPTY on output transfer with no accept.
  - TWO to ONE on output transfer: skid moves to main; no accept possible.
- Latency: 1 cycle from accept to alu_valid_o. Throughput: 1 instruction/cycle when not stalled.
- Reset (async, rst_n=0):
  - alu_valid_o=0, inst_ready_o=1 after release.
  - aluop_o=0, op1_o=op2_o=0, rd_o=0, wen_o=0, illegal_o=0.
  - Both entries invalidated; an in-flight instruction is dropped.
- Regfile data is sampled only on the accept cycle. Hazards and forwarding are the caller's responsibility.

Optional Feature:
- Macro: ALU_ISSUE_WORD_OPS_EN.
- Defined:
  - Decode OP-IMM-32 0011011 (addiw, slliw, srliw, sraiw) and OP-32 0111011 (addw, subw, sllw, srlw, sraw).
  - Extra output port word_o (1 bit, reset 0) is set for these.
  - aluop is as for the 64-bit equivalents.
  - Shamt with inst[25]=1 on W-shifts is illegal.
- Undefined: port absent; these opcodes are illegal.

Test Plan:
- Reset then addi x5,x1,-3 with rs1=10, alu_ready_i=1 -> next cycle valid=1, aluop=0000, op1=10, op2=0xFFFF_FFFF_FFFF_FFFD, rd=5, wen=1.
- sub x3,x4,x6 (funct7 0100000) with rs1=7, rs2=9 -> aluop=0001, op1=7, op2=9; srai x2,x2,63 -> aluop=0101, op2=63.
- auipc x1,0x12345 at pc=0x8000_0000 -> aluop=0000, op1=0x8000_0000, op2=0x1234_5000; lui with rd=x0 -> wen=0.
- Hold alu_ready_i=0 and issue 3 back-to-back instructions -> first two captured, inst_ready_o=0 on cycle 3. Raise ready -> outputs appear in order with no duplicates or loss.
- Opcode 1111111 -> illegal_o=1, wen_o=0, op1=op2=0. slti 0x7FF vs 0x800 immediates -> sign-extension correct.
- Assert rst_n=0 mid-stall with both entries full -> alu_valid_o drops immediately (asynchronously); inst_ready_o=1 after release; no stale output.
